// File: rtl/score_display_tracker.sv
// Score/high-score BCD tracker with hit-streak timeout; streams the current
// score to the text display as a fixed-length ASCII frame, MSD first.
module score_display_tracker #(
  parameter int NUM_DIGITS     = 5,
  parameter int STREAK_TIMEOUT = 13_500_000,
  parameter int STREAK_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    score,
  input  logic                    hit,
  input  logic                    song_end,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic                    new_high,
  output logic [STREAK_W-1:0]     streak,
  output logic [7:0]              ascii_data,
  output logic                    ascii_valid,
  input  logic                    ascii_ready,
  output logic                    ascii_last
);

  localparam int SW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = (STREAK_TIMEOUT > 2) ? $clog2(STREAK_TIMEOUT) : 1;

  localparam logic [TW-1:0] TO_LAST   = TW'(STREAK_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_PRE    = TW'(STREAK_TIMEOUT - 2);
  localparam logic [SW-1:0] SCORE_MAX = {NUM_DIGITS{4'h9}};
  localparam logic [IW-1:0] IDX_MSD   = IW'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [SW-1:0]       score_q, score_d;
  logic [SW-1:0]       high_q, high_d;
  logic                new_high_q, new_high_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                pending_q, pending_d;
  logic [0:0]          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [SW-1:0]       snap_q, snap_d;
  logic [7:0]          ascii_data_q, ascii_data_d;
  logic                ascii_valid_q, ascii_valid_d;
  logic                ascii_last_q, ascii_last_d;

  logic [SW-1:0] score_inc;
  logic [SW-1:0] score_next;
  logic          carry;
  logic          score_changed;
  logic [3:0]    digit;

  // Score, high score and streak; a score pulse in the song_end cycle counts before the commit.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (score_q[i*4 +: 4] == 4'd9) begin
          score_inc[i*4 +: 4] = 4'd0;
        end else begin
          score_inc[i*4 +: 4] = score_q[i*4 +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    score_next = (score && (score_q != SCORE_MAX)) ? score_inc : score_q;

    score_d    = score_next;
    high_d     = high_q;
    new_high_d = new_high_q;
    streak_d   = streak_q;
    tcnt_d     = tcnt_q;

    if (song_end) begin
      score_d = '0;
      if (score_next > high_q) begin
        high_d     = score_next;
        new_high_d = 1'b1;
      end else begin
        new_high_d = 1'b0;
      end
    end else if (score) begin
      new_high_d = 1'b0;
    end

    if (hit && !song_end) begin
      tcnt_d = '0;
      if (streak_q != {STREAK_W{1'b1}}) streak_d = streak_q + STREAK_W'(1);
    end else begin
      if (tcnt_q >= TO_PRE) begin
        tcnt_d   = TO_LAST;
        streak_d = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
      if (song_end) streak_d = '0;
    end

    score_changed = (score_d != score_q);
  end

  // Frame sequencer: the snapshot is frozen for the whole frame, and a pending
  // change at the final beat starts the next frame without a gap.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    pending_d = pending_q | score_changed;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          snap_d    = score_q;
          idx_d     = IDX_MSD;
          state_d   = ST_SEND;
          pending_d = score_changed;
        end
      end
      ST_SEND: begin
        if (ascii_valid_q && ascii_ready) begin
          if (idx_q == '0) begin
            if (pending_q) begin
              snap_d    = score_q;
              idx_d     = IDX_MSD;
              pending_d = score_changed;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) digit = snap_d[i*4 +: 4];
    end
    ascii_valid_d = (state_d == ST_SEND);
    ascii_data_d  = ascii_valid_d ? (8'h30 + {4'h0, digit}) : 8'h00;
    ascii_last_d  = ascii_valid_d && (idx_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q       <= '0;
      high_q        <= '0;
      new_high_q    <= 1'b0;
      streak_q      <= '0;
      tcnt_q        <= '0;
      pending_q     <= 1'b0;
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      snap_q        <= '0;
      ascii_data_q  <= '0;
      ascii_valid_q <= 1'b0;
      ascii_last_q  <= 1'b0;
    end else begin
      score_q       <= score_d;
      high_q        <= high_d;
      new_high_q    <= new_high_d;
      streak_q      <= streak_d;
      tcnt_q        <= tcnt_d;
      pending_q     <= pending_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      ascii_data_q  <= ascii_data_d;
      ascii_valid_q <= ascii_valid_d;
      ascii_last_q  <= ascii_last_d;
    end
  end

  assign score_bcd   = score_q;
  assign high_bcd    = high_q;
  assign new_high    = new_high_q;
  assign streak      = streak_q;
  assign ascii_data  = ascii_data_q;
  assign ascii_valid = ascii_valid_q;
  assign ascii_last  = ascii_last_q;

endmodule

// File: tb/tb_score_display_tracker.sv
// Randomized and directed bench for score_display_tracker against an integer
// reference model of score, high score, streak and the ASCII frame stream.
module tb_score_display_tracker;

  localparam int ND   = 5;
  localparam int TO   = 40;
  localparam int MAXV = 99999;

  logic        clk = 1'b0;
  logic        reset, score, hit, song_end, ascii_ready;
  logic [19:0] score_bcd, high_bcd;
  logic        new_high;
  logic [7:0]  streak, ascii_data;
  logic        ascii_valid, ascii_last;

  logic        sat_score, sat_zero, sat_ready;
  logic [11:0] sat_score_bcd, sat_high_bcd;
  logic        sat_new_high;
  logic [7:0]  sat_streak, sat_ascii_data;
  logic        sat_ascii_valid, sat_ascii_last;

  score_display_tracker #(.NUM_DIGITS(ND), .STREAK_TIMEOUT(TO), .STREAK_W(8)) dut (
    .clk(clk), .reset(reset), .score(score), .hit(hit), .song_end(song_end),
    .score_bcd(score_bcd), .high_bcd(high_bcd), .new_high(new_high), .streak(streak),
    .ascii_data(ascii_data), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .ascii_last(ascii_last)
  );

  // Three-digit instance so saturation is reachable within a short run.
  score_display_tracker #(.NUM_DIGITS(3)) sat_dut (
    .clk(clk), .reset(reset), .score(sat_score), .hit(sat_zero), .song_end(sat_zero),
    .score_bcd(sat_score_bcd), .high_bcd(sat_high_bcd), .new_high(sat_new_high),
    .streak(sat_streak), .ascii_data(sat_ascii_data), .ascii_valid(sat_ascii_valid),
    .ascii_ready(sat_ready), .ascii_last(sat_ascii_last)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int m_score, m_high, m_streak, m_idle;
  bit m_nh;
  bit dirty;
  bit seen[int];

  int beats, cur_val, last_frame;
  int frame_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic modelStep(input bit sc, input bit ht, input bit se, input bit rst);
    int nxt, old;
    if (rst) begin
      m_score = 0; m_high = 0; m_streak = 0; m_idle = 0; m_nh = 0; dirty = 0;
      seen.delete();
      seen[0] = 1;
      return;
    end
    old = m_score;
    nxt = (sc && m_score < MAXV) ? m_score + 1 : m_score;
    if (se) begin
      if (nxt > m_high) begin m_high = nxt; m_nh = 1; end
      else m_nh = 0;
      m_score = 0;
    end else begin
      m_score = nxt;
      if (sc) m_nh = 0;
    end
    if (m_score != old) begin dirty = 1; seen[m_score] = 1; end
    if (ht && !se) begin
      m_idle = 0;
      if (m_streak < 255) m_streak++;
    end else begin
      if (m_idle < TO - 1) m_idle++;
      if (m_idle == TO - 1 || se) m_streak = 0;
    end
  endtask

  task automatic applyStimulus(input bit sc, input bit ht, input bit se, input bit rdy, input bit rst);
    logic       pv, pl;
    logic [7:0] pd;
    bit         acc;
    score = sc; hit = ht; song_end = se; ascii_ready = rdy; reset = rst;
    pv  = ascii_valid;
    pd  = ascii_data;
    pl  = ascii_last;
    acc = (pv === 1'b1) && rdy && !rst;
    @(posedge clk);
    modelStep(sc, ht, se, rst);
    if (rst) begin
      beats = 0; cur_val = 0; last_frame = -1;
    end else if (acc) begin
      checkOutput("beat_digit_range", (pd >= 8'h30 && pd <= 8'h39), 1);
      checkOutput("beat_last_flag", pl, beats == ND - 1);
      cur_val = cur_val * 10 + int'(pd - 8'h30);
      beats++;
      if (beats == ND) begin
        checkOutput("frame_value_seen", seen.exists(cur_val), 1);
        last_frame = cur_val;
        frame_q.push_back(cur_val);
        beats = 0; cur_val = 0;
      end
    end
    #1;
    checkOutput("score_bcd", score_bcd, to_bcd(m_score));
    checkOutput("high_bcd", high_bcd, to_bcd(m_high));
    checkOutput("new_high", new_high, m_nh);
    checkOutput("streak", streak, m_streak);
    if (rst) begin
      checkOutput("reset_valid", ascii_valid, 0);
      checkOutput("reset_data", ascii_data, 0);
      checkOutput("reset_last", ascii_last, 0);
    end else if (pv === 1'b1 && !rdy) begin
      checkOutput("stall_valid", ascii_valid, 1);
      checkOutput("stall_data", ascii_data, pd);
      checkOutput("stall_last", ascii_last, pl);
    end
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    repeat (n) applyStimulus(0, 0, 0, rdy, 0);
  endtask

  task automatic satPulses(input int n);
    sat_score = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    sat_score = 1'b0;
  endtask

  initial begin
    int f0;
    score = 0; hit = 0; song_end = 0; ascii_ready = 1; reset = 1;
    sat_score = 0; sat_zero = 0; sat_ready = 1;
    beats = 0; cur_val = 0; last_frame = -1;

    repeat (3) applyStimulus(0, 0, 0, 1, 1);
    checkOutput("reset_score_zero", score_bcd, 0);

    // First frame timing and content after three pulses
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("valid_after_edge1", ascii_valid, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("valid_after_edge2", ascii_valid, 1);
    applyStimulus(1, 0, 0, 1, 0);
    idleCycles(20, 1);
    checkOutput("score_three", score_bcd, 20'h00003);
    checkOutput("frame_three", last_frame, 3);

    // BCD carries
    applyStimulus(0, 0, 0, 1, 1);
    repeat (9) applyStimulus(1, 0, 0, 1, 0);
    checkOutput("score_nine", score_bcd, 20'h00009);
    repeat (10) applyStimulus(1, 0, 0, 1, 0);
    checkOutput("score_nineteen", score_bcd, 20'h00019);
    repeat (80) applyStimulus(1, 0, 0, 1, 0);
    checkOutput("score_99", score_bcd, 20'h00099);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("score_100", score_bcd, 20'h00100);

    // High score commit and non-commit
    applyStimulus(0, 0, 0, 1, 1);
    repeat (42) applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("high_42", high_bcd, 20'h00042);
    checkOutput("new_high_set", new_high, 1);
    checkOutput("score_cleared", score_bcd, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("new_high_cleared", new_high, 0);
    repeat (16) applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("high_kept_42", high_bcd, 20'h00042);
    checkOutput("new_high_not_set", new_high, 0);

    // Streak saturation and timeout
    applyStimulus(0, 0, 0, 1, 1);
    repeat (300) begin
      applyStimulus(0, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
    end
    checkOutput("streak_sat", streak, 255);
    idleCycles(TO, 1);
    checkOutput("streak_timeout", streak, 0);
    applyStimulus(0, 1, 0, 1, 0);
    idleCycles(TO - 2, 1);
    checkOutput("streak_survives", streak, 1);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("streak_two", streak, 2);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("streak_song_end", streak, 0);

    // Back-pressure mid-frame, then a change during the frame
    applyStimulus(0, 0, 0, 1, 1);
    f0 = frame_q.size();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stall_frame_valid", ascii_valid, 1);
    idleCycles(10, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    idleCycles(20, 1);
    checkOutput("two_frames", frame_q.size(), f0 + 2);
    if (frame_q.size() >= f0 + 2) begin
      checkOutput("frame_one", frame_q[f0], 1);
      checkOutput("frame_two", frame_q[f0+1], 2);
    end

    // Reset aborts a frame in flight
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1);
    f0 = frame_q.size();
    repeat (10) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("no_resume", ascii_valid, 0);
    end
    checkOutput("no_partial_frame", frame_q.size(), f0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 299) == 0);
    end
    idleCycles(30, 1);
    if (dirty) checkOutput("quiesce_frame", last_frame, m_score);
    checkOutput("quiesce_idle", ascii_valid, 0);

    // Saturation on the three-digit instance
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0);
    satPulses(99);
    checkOutput("sat_099", sat_score_bcd, 12'h099);
    satPulses(1);
    checkOutput("sat_100", sat_score_bcd, 12'h100);
    satPulses(899);
    checkOutput("sat_999", sat_score_bcd, 12'h999);
    satPulses(20);
    checkOutput("sat_hold_999", sat_score_bcd, 12'h999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
